// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with standard or first-word-fall-through read,
// live fill count, programmable almost levels, synchronous flush and sticky error flags.
module sync_fifo_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter bit FWFT   = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_wr,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_rd,
    input  logic              i_flush,
    input  logic              i_clr_err,
    input  logic [ADDR_W:0]   i_afull_lvl,
    input  logic [ADDR_W:0]   i_aempty_lvl,
    output logic [DATA_W-1:0] o_data,
    output logic [ADDR_W:0]   o_count,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_almost_full,
    output logic              o_almost_empty,
    output logic              o_overflow,
    output logic              o_underflow
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   wrptr, rdptr;
    logic              rd_acc, wr_acc;

    // the extra pointer bit distinguishes a full ring from an empty one
    assign o_count        = wrptr - rdptr;
    assign o_empty        = wrptr == rdptr;
    assign o_full         = (wrptr[ADDR_W-1:0] == rdptr[ADDR_W-1:0]) && (wrptr[ADDR_W] != rdptr[ADDR_W]);
    assign o_almost_full  = o_count >= i_afull_lvl;
    assign o_almost_empty = o_count <= i_aempty_lvl;
    assign rd_acc         = i_rd & ~o_empty & ~i_flush;
    assign wr_acc         = i_wr & ~i_flush & (~o_full | rd_acc);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wrptr       <= '0;
            rdptr       <= '0;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            wrptr       <= i_flush ? '0 : wrptr + (ADDR_W+1)'(wr_acc);
            rdptr       <= i_flush ? '0 : rdptr + (ADDR_W+1)'(rd_acc);
            o_overflow  <= (i_wr & ~i_flush & ~wr_acc) | (o_overflow & ~i_clr_err);
            o_underflow <= (i_rd & ~i_flush & ~rd_acc) | (o_underflow & ~i_clr_err);
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_acc) mem[wrptr[ADDR_W-1:0]] <= i_data;
    end

    generate
        if (FWFT) begin : g_fwft
            assign o_data = mem[rdptr[ADDR_W-1:0]];
        end else begin : g_std
            always_ff @(posedge i_clk or negedge i_reset_n) begin
                if (!i_reset_n) o_data <= '0;
                else if (rd_acc) o_data <= mem[rdptr[ADDR_W-1:0]];
            end
        end
    endgenerate
endmodule
